ddr_port_arbiter: RTL and testbench

DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

---
 rtl/ddr_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one DDR port between two requesters, one transaction at a time.
// Define ARB_FIXED_PRIORITY_EN to make port 0 win every simultaneous request instead of round-robin.
module ddr_port_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         p0_valid,
   input  logic         p0_rw,
   input  logic [27:0]  p0_addr,
   input  logic [255:0] p0_wr_data,
   output logic         p0_ready,
   output logic [255:0] p0_rd_data,
   input  logic         p1_valid,
   input  logic         p1_rw,
   input  logic [27:0]  p1_addr,
   input  logic [255:0] p1_wr_data,
   output logic         p1_ready,
   output logic [255:0] p1_rd_data,
   output logic [27:0]  mem_data_addr,
   output logic [255:0] mem_data_wr,
   output logic         mem_rw_data,
   output logic         mem_valid_data,
   input  logic [255:0] mem_data_rd,
   input  logic         mem_ready_data,
   output logic [1:0]   grant,
   output logic         busy,
   output logic         err_timeout,
   input  logic         err_clr
);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [1:0]   state_q, state_d, grant_q, grant_d, rdy_q, rdy_d;
   logic         busy_q, busy_d, err_q, err_d, mem_rw_q, mem_rw_d, mem_valid_q, mem_valid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [27:0]  mem_addr_q, mem_addr_d;
   logic [255:0] mem_wr_q, mem_wr_d, rd0_q, rd0_d, rd1_q, rd1_d, rd_new;
   logic         win1, tmo, fin, load_rd;

   assign tmo     = (cnt_q == CW'(TIMEOUT - 1));
   assign fin     = (state_q == BUSY) & (mem_ready_data | tmo);
   assign rd_new  = mem_ready_data ? mem_data_rd : '0;
   assign load_rd = ~mem_ready_data | ~mem_rw_q;

`ifdef ARB_FIXED_PRIORITY_EN
   assign win1 = p1_valid & ~p0_valid;
`else
   logic last_grant_q, last_grant_d;
   // last_grant names the port served most recently; the other one wins a tie
   assign win1 = p1_valid & (~p0_valid | ~last_grant_q);
   assign last_grant_d = fin ? grant_q[1] : last_grant_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_grant_q <= 1'b1;
      else last_grant_q <= last_grant_d;
   end
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wr_d    = mem_wr_q;
      mem_rw_d    = mem_rw_q;
      mem_valid_d = mem_valid_q;
      rdy_d       = 2'b00;
      rd0_d       = rd0_q;
      rd1_d       = rd1_q;
      err_d       = err_clr ? 1'b0 : err_q;
      if (state_q == IDLE) begin
         if (p0_valid || p1_valid) begin
            state_d     = BUSY;
            grant_d     = win1 ? 2'b10 : 2'b01;
            busy_d      = 1'b1;
            cnt_d       = '0;
            mem_addr_d  = win1 ? p1_addr : p0_addr;
            mem_wr_d    = win1 ? p1_wr_data : p0_wr_data;
            mem_rw_d    = win1 ? p1_rw : p0_rw;
            mem_valid_d = 1'b1;
         end
      end else if (state_q == BUSY) begin
         if (fin) begin
            state_d     = DONE;
            mem_valid_d = 1'b0;
            rdy_d       = grant_q;
            err_d       = mem_ready_data ? err_d : 1'b1;
            rd0_d       = (grant_q[0] && load_rd) ? rd_new : rd0_q;
            rd1_d       = (grant_q[1] && load_rd) ? rd_new : rd1_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         state_d = IDLE;
         grant_d = 2'b00;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         grant_q     <= 2'b00;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wr_q    <= '0;
         mem_rw_q    <= 1'b0;
         mem_valid_q <= 1'b0;
         rdy_q       <= 2'b00;
         rd0_q       <= '0;
         rd1_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wr_q    <= mem_wr_d;
         mem_rw_q    <= mem_rw_d;
         mem_valid_q <= mem_valid_d;
         rdy_q       <= rdy_d;
         rd0_q       <= rd0_d;
         rd1_q       <= rd1_d;
         err_q       <= err_d;
      end
   end

   assign p0_ready       = rdy_q[0];
   assign p1_ready       = rdy_q[1];
   assign p0_rd_data     = rd0_q;
   assign p1_rd_data     = rd1_q;
   assign mem_data_addr  = mem_addr_q;
   assign mem_data_wr    = mem_wr_q;
   assign mem_rw_data    = mem_rw_q;
   assign mem_valid_data = mem_valid_q;
   assign grant          = grant_q;
   assign busy           = busy_q;
   assign err_timeout    = err_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed scenarios for ddr_port_arbiter with TIMEOUT=16.
module tb_ddr_port_arbiter;
   logic         clk = 1'b0, rst = 1'b1;
   logic         p0_valid = 0, p0_rw = 0, p0_ready, p1_valid = 0, p1_rw = 0, p1_ready;
   logic [27:0]  p0_addr = '0, p1_addr = '0, mem_data_addr;
   logic [255:0] p0_wr_data = '0, p1_wr_data = '0, p0_rd_data, p1_rd_data;
   logic [255:0] mem_data_wr, mem_data_rd = '0, e_rd0 = '0, e_rd1 = '0, wdat;
   logic         mem_rw_data, mem_valid_data, mem_ready_data = 0;
   logic [1:0]   grant, e_grant;
   logic         busy, err_timeout, err_clr = 0;
   int           checks = 0, failures = 0;

   always #5 clk = ~clk;

   ddr_port_arbiter #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
      .p0_ready(p0_ready), .p0_rd_data(p0_rd_data),
      .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
      .p1_ready(p1_ready), .p1_rd_data(p1_rd_data),
      .mem_data_addr(mem_data_addr), .mem_data_wr(mem_data_wr), .mem_rw_data(mem_rw_data),
      .mem_valid_data(mem_valid_data), .mem_data_rd(mem_data_rd), .mem_ready_data(mem_ready_data),
      .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3 rst = 1'b0;
      #1;
      checks++; if ({mem_valid_data, busy, grant, err_timeout, p0_ready, p1_ready} !== 7'd0) begin failures++; $display("FAIL reset_ctrl got %b exp 0", {mem_valid_data, busy, grant, err_timeout, p0_ready, p1_ready}); end
      checks++; if ({mem_data_addr, mem_rw_data} !== 29'd0) begin failures++; $display("FAIL reset_addr got %h exp 0", mem_data_addr); end
      checks++; if ((p0_rd_data | p1_rd_data | mem_data_wr) !== 256'd0) begin failures++; $display("FAIL reset_data got nonzero exp 0"); end
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      wdat = {32{8'hA5}};
      p0_valid = 1; p0_rw = 1; p0_addr = 28'h3000000; p0_wr_data = wdat;
      tick();
      checks++; if ({mem_valid_data, mem_rw_data, grant, busy} !== 5'b11011) begin failures++; $display("FAIL wr_issue got %b exp 11011", {mem_valid_data, mem_rw_data, grant, busy}); end
      checks++; if (mem_data_addr !== 28'h3000000 || mem_data_wr !== wdat) begin failures++; $display("FAIL wr_payload got %h exp 3000000", mem_data_addr); end
      tick();
      tick();
      checks++; if ({mem_valid_data, p0_ready, mem_data_addr} !== {2'b10, 28'h3000000}) begin failures++; $display("FAIL wr_hold got %b%b exp 10", mem_valid_data, p0_ready); end
      mem_ready_data = 1;
      tick();
      mem_ready_data = 0; p0_valid = 0;
      checks++; if ({mem_valid_data, p0_ready, p1_ready, grant} !== 5'b01001) begin failures++; $display("FAIL wr_done got %b exp 01001", {mem_valid_data, p0_ready, p1_ready, grant}); end
      checks++; if (p0_rd_data !== e_rd0) begin failures++; $display("FAIL wr_rd_kept got %h exp %h", p0_rd_data, e_rd0); end
      tick();
      checks++; if ({p0_ready, grant, busy} !== 4'b0000) begin failures++; $display("FAIL wr_idle got %b exp 0000", {p0_ready, grant, busy}); end
   endtask

   task automatic test_read();
      p1_valid = 1; p1_rw = 0; p1_addr = 28'h3000008;
      tick();
      checks++; if ({grant, mem_rw_data, mem_valid_data, mem_data_addr} !== {4'b1001, 28'h3000008}) begin failures++; $display("FAIL rd_issue got %b %h exp 1001 3000008", {grant, mem_rw_data, mem_valid_data}, mem_data_addr); end
      tick();
      mem_data_rd = 256'h1234; mem_ready_data = 1; e_rd1 = 256'h1234;
      tick();
      mem_ready_data = 0; p1_valid = 0;
      checks++; if ({p1_ready, p0_ready} !== 2'b10) begin failures++; $display("FAIL rd_ready got %b exp 10", {p1_ready, p0_ready}); end
      checks++; if (p1_rd_data !== e_rd1) begin failures++; $display("FAIL rd_data got %h exp %h", p1_rd_data, e_rd1); end
      checks++; if (p0_rd_data !== e_rd0) begin failures++; $display("FAIL rd_other got %h exp %h", p0_rd_data, e_rd0); end
      tick();
   endtask

   task automatic test_ignore_ready();
      mem_ready_data = 1; mem_data_rd = 256'hDEAD;
      tick();
      tick();
      mem_ready_data = 0;
      checks++; if ({busy, p0_ready, p1_ready, mem_valid_data} !== 4'b0000) begin failures++; $display("FAIL idle_ready got %b exp 0000", {busy, p0_ready, p1_ready, mem_valid_data}); end
      checks++; if (p1_rd_data !== e_rd1 || p0_rd_data !== e_rd0) begin failures++; $display("FAIL idle_rd got %h exp %h", p1_rd_data, e_rd1); end
   endtask

   task automatic test_contention();
      p0_valid = 1; p1_valid = 1; p0_rw = 0; p1_rw = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
`ifdef ARB_FIXED_PRIORITY_EN
         e_grant = 2'b01;
`else
         e_grant = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
         checks++; if (grant !== e_grant) begin failures++; $display("FAIL cont_grant%0d got %b exp %b", i, grant, e_grant); end
         mem_data_rd = 256'(100 + i); mem_ready_data = 1;
         if (e_grant[0]) e_rd0 = 256'(100 + i); else e_rd1 = 256'(100 + i);
         tick();
         mem_ready_data = 0;
         checks++; if ({p1_ready, p0_ready, p0_rd_data, p1_rd_data} !== {e_grant, e_rd0, e_rd1}) begin failures++; $display("FAIL cont_done%0d got %b %h %h exp %b %h %h", i, {p1_ready, p0_ready}, p0_rd_data, p1_rd_data, e_grant, e_rd0, e_rd1); end
         tick();
      end
      p0_valid = 0; p1_valid = 0;
      tick();
   endtask

   task automatic test_timeout();
      int drops;
      for (int k = 0; k < 2; k++) begin
         drops = 0;
         p0_valid = 1; p0_rw = 0;
         tick();
         for (int c = 0; c < 15; c++) begin
            if (!mem_valid_data || p0_ready) drops++;
            tick();
         end
         checks++; if (drops !== 0) begin failures++; $display("FAIL tmo_early%0d got %0d exp 0", k, drops); end
         err_clr = (k == 1);
         tick();
         err_clr = 0; p0_valid = 0; e_rd0 = '0;
         checks++; if ({mem_valid_data, err_timeout, p0_ready, p1_ready} !== 4'b0110) begin failures++; $display("FAIL tmo_fire%0d got %b exp 0110", k, {mem_valid_data, err_timeout, p0_ready, p1_ready}); end
         checks++; if (p0_rd_data !== e_rd0 || p1_rd_data !== e_rd1) begin failures++; $display("FAIL tmo_rd%0d got %h %h exp %h %h", k, p0_rd_data, p1_rd_data, e_rd0, e_rd1); end
         tick();
         checks++; if ({err_timeout, busy, p0_ready} !== 3'b100) begin failures++; $display("FAIL tmo_sticky%0d got %b exp 100", k, {err_timeout, busy, p0_ready}); end
         if (k == 0) begin
            err_clr = 1;
            tick();
            err_clr = 0;
            checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clr got %b exp 0", err_timeout); end
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      int rdy_seen = 0;
      p1_valid = 1; p1_rw = 0; p1_addr = 28'h3000008;
      tick();
      tick();
      tick();
      rst = 0;
      #1;
      e_rd0 = '0; e_rd1 = '0;
      checks++; if ({mem_valid_data, busy, grant, err_timeout, p1_ready, mem_rw_data} !== 7'd0 || mem_data_addr !== 28'd0) begin failures++; $display("FAIL rstb_async got %b %h exp 0", {mem_valid_data, busy, grant, err_timeout, p1_ready, mem_rw_data}, mem_data_addr); end
      checks++; if (p1_rd_data !== e_rd1 || p0_rd_data !== e_rd0) begin failures++; $display("FAIL rstb_rd got %h exp 0", p1_rd_data); end
      for (int c = 0; c < 2; c++) begin
         tick();
         if (p1_ready || p0_ready || busy) rdy_seen++;
      end
      rst = 1;
      checks++; if (rdy_seen !== 0) begin failures++; $display("FAIL rstb_noready got %0d exp 0", rdy_seen); end
      tick();
      checks++; if ({grant, mem_valid_data, busy, mem_data_addr} !== {4'b1011, 28'h3000008}) begin failures++; $display("FAIL rstb_reissue got %b %h exp 1011 3000008", {grant, mem_valid_data, busy}, mem_data_addr); end
      mem_data_rd = 256'h55; mem_ready_data = 1; e_rd1 = 256'h55;
      tick();
      mem_ready_data = 0; p1_valid = 0;
      checks++; if ({p1_ready, p1_rd_data} !== {1'b1, e_rd1}) begin failures++; $display("FAIL rstb_serve got %b %h exp 1 %h", p1_ready, p1_rd_data, e_rd1); end
      tick();
      checks++; if ({p1_ready, busy, grant} !== 4'b0000) begin failures++; $display("FAIL rstb_idle got %b exp 0000", {p1_ready, busy, grant}); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_ignore_ready();
      test_contention();
      test_timeout();
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
